// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sharing arbiter and its datapath slice.
package alu_pkg;

  localparam int WIDTH_DEF = 16;

  // Bit of alu_fn that selects subtract (invert B, carry-in = 1).
  localparam int FN_SUB = 0;

  // alu_fn[2:1] compare selections.
  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_EQ   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_LE   = 2'b11;

  // Arbiter FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu_slice.sv
// Combinational add/sub datapath: lookahead adder, {z,v,n} flags and compare.
module alu_slice
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fn,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [2:0]       zvn,
  output logic             cmp
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             z;
  logic             v;
  logic             n;

  assign sub   = fn[FN_SUB];
  assign b_eff = sub ? ~b : b;
  assign g     = a & b_eff;
  assign p     = a ^ b_eff;

  // Carry lookahead: each carry expressed from generate/propagate terms.
  always_comb begin
    c    = '0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

  // Overflow uses the original B: operands agree in sign (after the subtract
  // flip) yet the result sign differs from A.
  assign z   = ~|sum;
  assign n   = sum[WIDTH-1];
  assign v   = (a[WIDTH-1] ~^ (b[WIDTH-1] ^ sub)) & (sum[WIDTH-1] ^ a[WIDTH-1]);
  assign zvn = {z, v, n};

  // Signed compare derived from the flags of A - B.
  always_comb begin
    cmp = 1'b0;
    case (fn[2:1])
      CMP_EQ:  cmp = z;
      CMP_LT:  cmp = n ^ v;
      CMP_LE:  cmp = z | (n ^ v);
      default: cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU slice between two valid/ready requesters,
// with a single registered response channel tagged by requester id.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_fn,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic [2:0]            resp_zvn,
  output logic                  resp_cmp,
  output logic                  resp_cout
);

  logic [1:0]       state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_fn;
  logic             op_id;

  logic             any_valid;
  logic             winner;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_fn;

  logic [WIDTH-1:0] alu_sum;
  logic             alu_cout;
  logic [2:0]       alu_zvn;
  logic             alu_cmp;

  // Round-robin pick: on a tie the requester that was not served last wins.
  always_comb begin
    any_valid = |req_valid;
    if (req_valid[0] && req_valid[1]) winner = ~last_grant;
    else                              winner = req_valid[1];
    req_ready = '0;
    if (state == ST_IDLE && any_valid) req_ready[winner] = 1'b1;
    accept = state == ST_IDLE && any_valid;
    sel_a  = winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    sel_b  = winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    sel_fn = winner ? req_fn[5:3] : req_fn[2:0];
  end

  alu_slice #(.WIDTH(WIDTH)) u_alu_slice (
    .a    (op_a),
    .b    (op_b),
    .fn   (op_fn),
    .sum  (alu_sum),
    .cout (alu_cout),
    .zvn  (alu_zvn),
    .cmp  (alu_cmp)
  );

  // FSM, round-robin pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_fn      <= '0;
      op_id      <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_zvn   <= '0;
      resp_cmp   <= 1'b0;
      resp_cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_fn <= sel_fn;
            op_id <= winner;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data  <= alu_sum;
          resp_cout  <= alu_cout;
          resp_zvn   <= alu_zvn;
          resp_cmp   <= alu_cmp;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= resp_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expectations queued at accept,
// compared when the response handshakes.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic [2:0]  zvn;
    logic        cmp;
    logic        cout;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  req_fn;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_data;
  logic [2:0]  resp_zvn;
  logic        resp_cmp;
  logic        resp_cout;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  logic [15:0] pa [2];
  logic [15:0] pb [2];
  logic [2:0]  pf [2];

  alu_share_arbiter #(.WIDTH(16), .NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_fn     (req_fn),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_zvn   (resp_zvn),
    .resp_cmp   (resp_cmp),
    .resp_cout  (resp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] fn);
    exp_t e;
    logic [16:0] s;
    logic sub, lt;
    sub = fn[0];
    s = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {16'd0, sub};
    e.id   = id;
    e.data = s[15:0];
    e.cout = s[16];
    e.zvn[2] = (s[15:0] == 16'd0);
    e.zvn[0] = s[15];
    e.zvn[1] = sub ? ((a[15] != b[15]) && (s[15] != a[15]))
                   : ((a[15] == b[15]) && (s[15] != a[15]));
    lt = e.zvn[0] ^ e.zvn[1];
    case (fn[2:1])
      2'b01:   e.cmp = e.zvn[2];
      2'b10:   e.cmp = lt;
      2'b11:   e.cmp = e.zvn[2] | lt;
      default: e.cmp = 1'b0;
    endcase
    return e;
  endfunction

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] fn);
    pa[id] = a; pb[id] = b; pf[id] = fn;
    req_a  = {pa[1], pa[0]};
    req_b  = {pb[1], pb[0]};
    req_fn = {pf[1], pf[0]};
  endtask

  // Response scoreboard: pop one expectation per response handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      exp_t got, e;
      got = '{resp_id, resp_data, resp_zvn, resp_cmp, resp_cout};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected got id=%0d data=%h zvn=%b cmp=%b cout=%b want none",
                 got.id, got.data, got.zvn, got.cmp, got.cout);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL resp got id=%0d data=%h zvn=%b cmp=%b cout=%b want id=%0d data=%h zvn=%b cmp=%b cout=%b",
                   got.id, got.data, got.zvn, got.cmp, got.cout,
                   e.id, e.data, e.zvn, e.cmp, e.cout);
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (resp_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got %b want 0", resp_valid); end
    total++; if (resp_data !== 16'h0)   begin bad++; $display("FAIL rst_data got %h want 0000", resp_data); end
    total++; if (resp_zvn !== 3'b000)   begin bad++; $display("FAIL rst_zvn got %b want 000", resp_zvn); end
    total++; if (resp_cmp !== 1'b0)     begin bad++; $display("FAIL rst_cmp got %b want 0", resp_cmp); end
    total++; if (resp_cout !== 1'b0)    begin bad++; $display("FAIL rst_cout got %b want 0", resp_cout); end
    total++; if (resp_id !== 1'b0)      begin bad++; $display("FAIL rst_id got %b want 0", resp_id); end
    total++; if (req_ready !== 2'b00)   begin bad++; $display("FAIL rst_ready got %b want 00", req_ready); end
    resp_ready = 1'b1;
    total++; if (resp_valid !== 1'b0)   begin bad++; $display("FAIL idle_resp_ready got %b want 0", resp_valid); end
    @(posedge clk); #1;
  endtask

  // One command from one requester; checks grant, 2-cycle latency, and queues e.
  task automatic test_single(input int id, input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] fn, input exp_t e);
    logic [1:0] want_rdy;
    int n = 0;
    want_rdy = (id == 0) ? 2'b01 : 2'b10;
    resp_ready = 1'b1;
    set_req(id, a, b, fn);
    req_valid[id] = 1'b1;
    @(negedge clk);
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (req_ready !== want_rdy) begin
      bad++;
      $display("FAIL single_grant id=%0d got %b want %b", id, req_ready, want_rdy);
      req_valid[id] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    q.push_back(e);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL latency_early got %b want 0", resp_valid); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL latency_2cyc got %b want 1", resp_valid); end
    wait_drain();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_clear got %b want 0", resp_valid); end
  endtask

  task automatic test_fairness();
    int order[$];
    logic exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n = 0;
    int g;
    apply_reset();
    resp_ready = 1'b1;
    set_req(0, 16'h1000, 16'h0001, 3'b000);
    set_req(1, 16'h2000, 16'h0002, 3'b001);
    req_valid = 2'b11;
    while (order.size() < 4 && n < 60) begin
      @(negedge clk); n++;
      if (req_ready !== 2'b00) begin
        total++;
        if (!$onehot(req_ready)) begin bad++; $display("FAIL fair_onehot got %b want onehot", req_ready); end
        g = req_ready[1] ? 1 : 0;
        order.push_back(g);
        q.push_back(model(g[0], pa[g], pb[g], pf[g]));
        @(posedge clk); #1;
        set_req(g, pa[g] + 16'h0111, pb[g] + 16'h0003, pf[g] ^ 3'b110);
        if (order.size() == 4) req_valid = 2'b00;
      end
    end
    req_valid = 2'b00;
    total++;
    if (order.size() != 4) begin bad++; $display("FAIL fair_count got %0d want 4", order.size()); end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      total++;
      if (order[i] !== int'(exp_order[i])) begin
        bad++; $display("FAIL fair_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int n = 0;
    exp_t e1;
    resp_ready = 1'b0;
    set_req(0, 16'hA234, 16'h8000, 3'b101);
    req_valid = 2'b01;
    @(negedge clk);
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant got %b want 01", req_ready); end
    q.push_back('{1'b0, 16'h2234, 3'b000, 1'b0, 1'b1});
    @(posedge clk); #1;
    set_req(1, 16'h0005, 16'h0003, 3'b000);
    req_valid = 2'b10;
    e1 = '{1'b1, 16'h0008, 3'b000, 1'b0, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 16'h2234 || resp_zvn !== 3'b000 ||
          resp_cmp !== 1'b0 || resp_cout !== 1'b1 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b id=%b data=%h zvn=%b cmp=%b cout=%b rdy=%b want v=1 id=0 data=2234 zvn=000 cmp=0 cout=1 rdy=00",
                 i, resp_valid, resp_id, resp_data, resp_zvn, resp_cmp, resp_cout, req_ready);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b10) begin
      bad++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=10", resp_valid, req_ready);
    end
    q.push_back(e1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic seen;
    resp_ready = 1'b1;
    set_req(0, 16'h1234, 16'h1234, 3'b011);
    req_valid = 2'b01;
    @(negedge clk);
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %b want 0", resp_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (resp_valid !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_noresp got response want none"); end
    set_req(0, 16'h0003, 16'h0005, 3'b101);
    set_req(1, 16'h0009, 16'h0001, 3'b000);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rstmid_grant got %b want 01", req_ready); end
    if (req_ready === 2'b01) q.push_back(model(1'b0, pa[0], pb[0], pf[0]));
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_random();
    int id;
    logic [15:0] a, b;
    logic [2:0] fn;
    for (int i = 0; i < 8; i++) begin
      id = $urandom_range(0, 1);
      a  = 16'($urandom);
      b  = (i % 4 == 0) ? a : 16'($urandom);
      fn = 3'($urandom_range(0, 7));
      test_single(id, a, b, fn, model(id[0], a, b, fn));
    end
  endtask

  initial begin
    req_valid = 2'b00; resp_ready = 1'b0; rst_n = 1'b0;
    set_req(0, 16'h0, 16'h0, 3'b000);
    set_req(1, 16'h0, 16'h0, 3'b000);
    test_reset();
    test_single(0, 16'h0101, 16'h0011, 3'b101, '{1'b0, 16'h00F0, 3'b000, 1'b0, 1'b1});
    test_single(1, 16'hFFFF, 16'h0001, 3'b101, '{1'b1, 16'hFFFE, 3'b001, 1'b1, 1'b1});
    test_single(0, 16'h7FFF, 16'h0001, 3'b000, '{1'b0, 16'h8000, 3'b011, 1'b0, 1'b0});
    test_single(1, 16'h0000, 16'h0000, 3'b011, '{1'b1, 16'h0000, 3'b100, 1'b1, 1'b1});
    test_single(0, 16'h8000, 16'h0001, 3'b111, '{1'b0, 16'h7FFF, 3'b010, 1'b1, 1'b1});
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 16-bit add/sub + ZVN + compare datapath between two requesters.
- The datapath is built from carry_lookahead_adder, zvn and compare_unit.
- Each requester has a valid/ready command port. The block grants round-robin, registers operands, executes, and returns the result on one shared response channel tagged with the requester id.
- Sits between the icestick control FSMs and the ALU slice.

Parameters:
- WIDTH, 16, operand/result width.
- NREQ, 2, number of requesters (fixed at 2 in this revision).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, packed the same way.
- req_fn  in  NREQ*3  alu_fn per requester, packed 3 bits each.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  1  requester index of the response.
- resp_data  out  WIDTH  sum/difference.
- resp_zvn  out  3  {z,v,n}.
- resp_cmp  out  1  compare_unit output.
- resp_cout  out  1  adder carry-out.

Behaviour:
- fn decode:
  - fn[0]=1 selects subtract: B is inverted and cin=1.
  - fn[2:1] drives compare_unit: 00 -> 0, 01 EQ (z), 10 LT (n^v), 11 LE (z|(n^v)).
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick a winner by round-robin. Priority goes to the requester other than last_grant; last_grant resets to 1, so requester 0 wins the first tie.
  - req_ready[winner] is high combinationally in the same cycle. The others stay low.
  - On the handshake: capture a, b, fn and id into operand registers, then go to EXEC.
- EXEC:
  - The datapath evaluates on the registered operands.
  - Register data, cout, zvn, cmp and id into the response registers.
  - Set resp_valid=1 and go to RESP.
- RESP:
  - Hold all resp_* stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready: clear resp_valid, set last_grant=resp_id, go to IDLE.
- Timing:
  - Latency from accept to resp_valid is exactly 2 cycles.
  - Minimum initiation interval is 3 cycles (no overlap in this revision).
- req_ready is always 0 outside IDLE. A requester must hold valid and payload until it sees ready; the arbiter never drops a held request.
- Fairness: when both requesters are continuously valid, grants strictly alternate 0,1,0,1.
- Only one requester valid: it is granted regardless of last_grant.
- Arithmetic:
  - Two's complement, modulo 2^WIDTH.
  - v comes from zvn using the original B and fn[0].
  - cout is raw adder carry; for subtract, cout=1 means no borrow.
- Reset (async assert, synchronous deassert by external synchroniser):
  - state=IDLE, last_grant=1.
  - resp_valid=0, resp_data=0, resp_zvn=0, resp_cmp=0, resp_cout=0, resp_id=0.
  - Operand registers are cleared.
- Reset mid-operation: any in-flight command is discarded with no response.
- resp_ready asserted while resp_valid=0: ignored.

Decomposition:
- Shared package (alu_pkg) holds:
  - FN_SUB bit index.
  - CMP_NONE/EQ/LT/LE encodings.
  - State encodings IDLE/EXEC/RESP.
  - WIDTH default.
- One natural sub-module, alu_slice: wraps carry_lookahead_adder, zvn and compare_unit combinationally. The arbiter holds only FSM, RR pointer and registers.

Test Plan:
- Req0 only, a=0x0101, b=0x0011, fn=3'b101 -> resp after 2 cycles: id=0, data=0x00F0, zvn=000, cmp=0, cout=1.
- Req1 only, a=0xFFFF, b=0x0001, fn=3'b101 -> data=0xFFFE, zvn=001, cmp=1 (-1<1).
- Req0 only, a=0x7FFF, b=0x0001, fn=3'b000 -> data=0x8000, zvn=011, cmp=0, cout=0.
- Both valid continuously for 4 commands after reset -> grant order 0,1,0,1, one req_ready pulse each.
- Backpressure on a=0xA234, b=0x8000, fn=3'b101: hold resp_ready=0 for 5 cycles -> data=0x2234, cmp=0, all resp_* stable, req_ready stays 0; release -> return to IDLE next cycle.
- Assert rst_n=0 during EXEC -> resp_valid=0 immediately, no response after release, next grant goes to requester 0.
